// File: rtl/trace_pkg.sv
// +--------------------------------------------------------------------+
// | trace_pkg -- flag bit indices, recorder states, record width        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package trace_pkg;

  localparam int FLAG_REG  = 0;
  localparam int FLAG_MEM  = 1;
  localparam int FLAG_OVFL = 2;
  localparam int FLAG_HALT = 3;
  localparam int FLAG_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Record layout: {cycle, flags, reg_addr, reg_data, mem_addr, mem_data}
  function automatic int rec_width(input int cyc_w, input int reg_aw, input int data_w);
    return cyc_w + FLAG_W + reg_aw + 3 * data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_recorder_if.sv
// +--------------------------------------------------------------------+
// | commit_trace_recorder_if -- valid/ready record stream bundle        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface commit_trace_recorder_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/trace_fifo.sv
// +--------------------------------------------------------------------+
// | trace_fifo -- DEPTH-entry record FIFO with registered stream output |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                     i_CLK,
  input  wire logic                     i_RST,
  input  wire logic                     i_push,
  input  wire logic [W-1:0]             i_data,
  commit_trace_recorder_if.master       m_out,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    o_full   = (count_q == (AW+1)'(DEPTH));
    o_empty  = (count_q == '0);
    do_pop   = !o_empty && m_out.ready;
    // A full FIFO still takes a push when the head leaves on the same edge
    do_push  = i_push && (!o_full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_level     = count_q;
  assign m_out.valid = !o_empty;
  assign m_out.data  = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/commit_trace_recorder.sv
// +--------------------------------------------------------------------+
// | commit_trace_recorder -- stamps commit events into a trace stream   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module commit_trace_recorder
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 32
) (
  input  wire logic                  i_CLK,
  input  wire logic                  i_RST,
  input  wire logic                  i_En,
  input  wire logic                  i_RegWr,
  input  wire logic [REG_AW-1:0]     i_RegWrAddr,
  input  wire logic [DATA_W-1:0]     i_RegWrData,
  input  wire logic                  i_DMemWr,
  input  wire logic [DATA_W-1:0]     i_DMemAddr,
  input  wire logic [DATA_W-1:0]     i_DMemData,
  input  wire logic                  i_Ovfl,
  input  wire logic                  i_Halt,
  output logic                       o_Valid,
  input  wire logic                  i_Ready,
  output logic [CYC_W-1:0]           o_Cycle,
  output logic [3:0]                 o_Flags,
  output logic [REG_AW-1:0]          o_RegAddr,
  output logic [DATA_W-1:0]          o_RegData,
  output logic [DATA_W-1:0]          o_MemAddr,
  output logic [DATA_W-1:0]          o_MemData,
  output logic [$clog2(DEPTH):0]     o_Level,
  output logic [15:0]                o_Drops,
  output logic                       o_DropFlag,
  output logic                       o_Done
);

  localparam int REC_W = rec_width(CYC_W, REG_AW, DATA_W);

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [15:0]      drops_q, drops_d;
  logic             drop_flag_q, drop_flag_d;
  logic [FLAG_W-1:0] flags;
  logic [REC_W-1:0] rec;
  logic             evt;
  logic             fifo_full;
  logic             fifo_empty;

  commit_trace_recorder_if #(.W(REC_W)) rec_if ();

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    drops_d     = drops_q;
    drop_flag_d = drop_flag_q;
    flags            = '0;
    flags[FLAG_REG]  = i_RegWr;
    flags[FLAG_MEM]  = i_DMemWr;
    flags[FLAG_OVFL] = i_Ovfl;
    flags[FLAG_HALT] = i_Halt;
    evt = (state_q == ST_RUN) && (|flags);
    rec = {cycle_q, flags,
           {REG_AW{i_RegWr}} & i_RegWrAddr, {DATA_W{i_RegWr}} & i_RegWrData,
           {DATA_W{i_DMemWr}} & i_DMemAddr, {DATA_W{i_DMemWr}} & i_DMemData};

    case (state_q)
      ST_IDLE: begin
        cycle_d = '0;
        if (i_En) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_d = cycle_q + CYC_W'(1);
        if (i_Halt) state_d = ST_STOP;
      end
      ST_STOP: state_d = ST_STOP;
      default: state_d = ST_IDLE;
    endcase

    if (evt && fifo_full && !(rec_if.valid && i_Ready)) begin
      drop_flag_d = 1'b1;
      if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      drops_q     <= '0;
      drop_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      drops_q     <= drops_d;
      drop_flag_q <= drop_flag_d;
    end
  end

  assign rec_if.ready = i_Ready;

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_push  (evt),
    .i_data  (rec),
    .m_out   (rec_if),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_Level)
  );

  assign o_Valid = rec_if.valid;
  assign {o_Cycle, o_Flags, o_RegAddr, o_RegData, o_MemAddr, o_MemData} = rec_if.data;
  assign o_Drops    = drops_q;
  assign o_DropFlag = drop_flag_q;
  assign o_Done     = (state_q == ST_STOP) && fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_recorder.sv
// +--------------------------------------------------------------------+
// | tb_commit_trace_recorder -- directed+random bench with queue model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_commit_trace_recorder;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 4;
  localparam int CYC_W  = 32;
  localparam int REC_W  = CYC_W + 4 + REG_AW + 3 * DATA_W;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  typedef struct {
    logic [31:0] cyc;
    logic [3:0]  fl;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] ma;
    logic [31:0] md;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, regwr = 1'b0, dmemwr = 1'b0, ovfl = 1'b0, halt = 1'b0;
  logic [4:0]  regaddr = '0;
  logic [31:0] regdata = '0, dmemaddr = '0, dmemdata = '0;
  logic [31:0] o_cycle, o_regdata, o_memaddr, o_memdata;
  logic [3:0]  o_flags;
  logic [4:0]  o_regaddr;
  logic [2:0]  o_level;
  logic [15:0] o_drops;
  logic        o_dropflag, o_done;

  commit_trace_recorder_if #(.W(REC_W)) mon ();

  assign mon.data = {o_cycle, o_flags, o_regaddr, o_regdata, o_memaddr, o_memdata};

  always #5 clk = ~clk;

  commit_trace_recorder #(
    .DATA_W (DATA_W), .REG_AW (REG_AW), .DEPTH (DEPTH), .CYC_W (CYC_W)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst_n),
    .i_En        (en),
    .i_RegWr     (regwr),
    .i_RegWrAddr (regaddr),
    .i_RegWrData (regdata),
    .i_DMemWr    (dmemwr),
    .i_DMemAddr  (dmemaddr),
    .i_DMemData  (dmemdata),
    .i_Ovfl      (ovfl),
    .i_Halt      (halt),
    .o_Valid     (mon.valid),
    .i_Ready     (mon.ready),
    .o_Cycle     (o_cycle),
    .o_Flags     (o_flags),
    .o_RegAddr   (o_regaddr),
    .o_RegData   (o_regdata),
    .o_MemAddr   (o_memaddr),
    .o_MemData   (o_memdata),
    .o_Level     (o_level),
    .o_Drops     (o_drops),
    .o_DropFlag  (o_dropflag),
    .o_Done      (o_done)
  );

  // Reference model: a queue of expected records plus run bookkeeping
  rec_t        q[$];
  int          m_state;
  logic [31:0] m_cyc;
  int          m_drops;
  bit          m_dflag;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = M_IDLE;
    m_cyc   = '0;
    m_drops = 0;
    m_dflag = 1'b0;
  endtask

  task automatic model_edge();
    rec_t r;
    if (q.size() != 0 && mon.ready) void'(q.pop_front());
    if (m_state == M_RUN && (regwr || dmemwr || ovfl || halt)) begin
      r.cyc = m_cyc;
      r.fl  = {halt, ovfl, dmemwr, regwr};
      r.ra  = regwr  ? regaddr  : 5'd0;
      r.rd  = regwr  ? regdata  : 32'd0;
      r.ma  = dmemwr ? dmemaddr : 32'd0;
      r.md  = dmemwr ? dmemdata : 32'd0;
      if (q.size() < DEPTH) q.push_back(r);
      else begin
        m_dflag = 1'b1;
        if (m_drops < 16'hFFFF) m_drops++;
      end
    end
    if (m_state == M_IDLE) begin
      m_cyc = '0;
      if (en) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      m_cyc = m_cyc + 32'd1;
      if (halt) m_state = M_STOP;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":valid"}, mon.valid, q.size() != 0);
    chk({tag, ":level"}, o_level, q.size());
    chk({tag, ":drops"}, o_drops, m_drops);
    chk({tag, ":dflag"}, o_dropflag, m_dflag);
    chk({tag, ":done"}, o_done, (m_state == M_STOP) && (q.size() == 0));
    if (q.size() != 0) begin
      chk({tag, ":cycle"}, o_cycle, q[0].cyc);
      chk({tag, ":flags"}, o_flags, q[0].fl);
      chk({tag, ":raddr"}, o_regaddr, q[0].ra);
      chk({tag, ":rdata"}, o_regdata, q[0].rd);
      chk({tag, ":maddr"}, o_memaddr, q[0].ma);
      chk({tag, ":mdata"}, o_memdata, q[0].md);
    end
  endtask

  task automatic drive(input bit e, input bit rw, input bit mw, input bit ov, input bit ht, input bit rdy);
    en = e; regwr = rw; dmemwr = mw; ovfl = ov; halt = ht; mon.ready = rdy;
    regaddr  = 5'($urandom_range(0, 31));
    regdata  = $urandom;
    dmemaddr = $urandom;
    dmemdata = $urandom;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    chk({tag, ":rvalid"}, mon.valid, 1'b0);
    chk({tag, ":rlevel"}, o_level, 3'd0);
    chk({tag, ":rdrops"}, o_drops, 16'd0);
    chk({tag, ":rfields"}, {o_cycle, o_flags, o_regaddr}, 64'd0);
    chk({tag, ":rdata"}, {o_regdata, o_memaddr}, 64'd0);
    chk({tag, ":rmdata"}, o_memdata, 32'd0);
    chk({tag, ":rdone"}, o_done, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    mon.ready = 1'b0;
    @(negedge clk);
    async_reset("reset0");

    // Run 1: first-record latency and field packing
    drive(1, 0, 0, 0, 0, 0); step("en");
    drive(0, 1, 0, 0, 0, 0); regaddr = 5'h01; regdata = 32'h1; step("first");
    chk("first:const_cycle", o_cycle, 32'd0);
    chk("first:const_flags", o_flags, 4'h1);
    chk("first:const_raddr", o_regaddr, 5'h01);
    chk("first:const_rdata", o_regdata, 32'h1);
    for (int k = 0; k < 20 && m_cyc != 32'd5; k++) begin
      drive(0, 0, 0, 0, 0, 1); step("gap");
    end
    drive(0, 1, 1, 1, 0, 0); dmemaddr = 32'h10010000; dmemdata = 32'hDEADBEEF; step("multi");
    chk("multi:const_flags", o_flags, 4'h7);
    chk("multi:const_cycle", o_cycle, 32'd5);
    chk("multi:const_maddr", o_memaddr, 32'h10010000);
    chk("multi:const_mdata", o_memdata, 32'hDEADBEEF);
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      drive(0, 0, 0, 0, 0, 1); step("drain1");
    end

    // Overflow: six events into a four-entry FIFO with the sink stalled
    for (int k = 0; k < 6; k++) begin
      drive(0, $urandom_range(0, 1), 1, $urandom_range(0, 1), 0, 0); step("fill");
    end
    chk("ovf:const_level", o_level, 3'd4);
    chk("ovf:const_drops", o_drops, 16'd2);
    chk("ovf:const_dflag", o_dropflag, 1'b1);
    drive(0, 1, 0, 0, 0, 1); step("fullpop");
    chk("fullpop:const_level", o_level, 3'd4);
    chk("fullpop:const_drops", o_drops, 16'd2);
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      drive(0, 0, 0, 0, 0, 1); step("drain2");
    end
    for (int k = 0; k < 60; k++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
            0, $urandom_range(0, 1));
      step("rand");
    end

    // Run 2: halt at cycle 9, later commits ignored
    @(negedge clk);
    async_reset("reset1");
    drive(1, 0, 0, 0, 0, 1); step("en2");
    for (int k = 0; k < 20 && m_cyc != 32'd9; k++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 1); step("pre_halt");
    end
    drive(0, 1, 0, 0, 1, 0); step("halt");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0); step("post_halt");
    end
    for (int k = 0; k < 10 && q.size() > 1; k++) begin
      drive(0, 0, 0, 0, 0, 1); step("drain3");
    end
    chk("last:const_cycle", o_cycle, 32'd9);
    chk("last:const_halt", o_flags[3], 1'b1);
    drive(0, 0, 0, 0, 0, 1); step("drain_last");
    drive(0, 1, 1, 0, 0, 1); step("stopped");
    chk("done:const", o_done, 1'b1);
    chk("done:const_level", o_level, 3'd0);

    // Run 3: reset with records pending, then no recording until re-enabled
    @(negedge clk);
    async_reset("reset2");
    drive(1, 0, 0, 0, 0, 0); step("en3");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, $urandom_range(0, 1), 0, 0, 0); step("queue3");
    end
    chk("queue3:const_level", o_level, 3'd3);
    async_reset("midreset");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 1, 0, 1); step("no_en");
    end
    drive(1, 1, 0, 0, 0, 1); step("en4");
    drive(0, 1, 0, 0, 0, 1); step("resume");
    chk("resume:const_cycle", o_cycle, 32'd0);
    drive(0, 0, 0, 0, 0, 1); step("idle_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_trace_recorder.md
COMMIT_TRACE_RECORDER -- requirements
Module: commit_trace_recorder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data and memory address width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning trace FIFO entries (power of 2, at least 2).
REQ-004 SHALL have parameter CYC_W, default 32, meaning cycle stamp width.
REQ-005 SHALL have ports: i_CLK in 1, clock; i_RST in 1, reset. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i_En in 1: start recording.
REQ-007 SHALL have ports i_RegWr in 1, i_RegWrAddr in REG_AW and i_RegWrData in DATA_W: register-write commit.
REQ-008 SHALL have ports i_DMemWr in 1, i_DMemAddr in DATA_W and i_DMemData in DATA_W: memory-write commit.
REQ-009 SHALL have ports i_Ovfl in 1 (arithmetic overflow) and i_Halt in 1 (halt commit).
REQ-010 SHALL have ports o_Valid out 1, i_Ready in 1, o_Cycle out CYC_W, o_Flags out 4 ({halt,ovfl,mem,reg}), o_RegAddr out REG_AW, o_RegData out DATA_W, o_MemAddr out DATA_W and o_MemData out DATA_W: trace record stream.
REQ-011 SHALL have ports o_Level out clog2(DEPTH)+1 (occupancy), o_Drops out 16 (dropped-record count), o_DropFlag out 1 (sticky) and o_Done out 1 (halted and drained).

Function
REQ-012 SHALL implement states IDLE, RUN and STOP; IDLE->RUN when i_En=1; RUN->STOP on the cycle i_Halt=1 is sampled; STOP exits only by reset.
REQ-013 SHALL keep a cycle counter at 0 in IDLE, increment it by 1 each RUN cycle with wrap-around at 2^CYC_W, and freeze it in STOP.
REQ-014 SHALL, in RUN, form one record per cycle in which any of i_RegWr, i_DMemWr, i_Ovfl or i_Halt is 1, stamped with the current counter value; cycles with no event produce no record.
REQ-015 SHALL zero unused record fields, e.g. reg fields when i_RegWr=0.
REQ-016 SHALL record the halt cycle, including any same-cycle reg, mem or ovfl events; inputs in IDLE and STOP are ignored.
REQ-017 SHALL push records into a DEPTH-entry FIFO; a record sampled at edge N appears on the output at earliest after edge N (registered, 1-cycle latency).
REQ-018 SHALL pop on the edge where o_Valid=1 and i_Ready=1; output fields are stable while o_Valid=1 and i_Ready=0.
REQ-019 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle; level is unchanged.
REQ-020 SHALL, on push with the FIFO full and no pop, drop the record, increment o_Drops (saturating at 0xFFFF) and set o_DropFlag until reset.
REQ-021 SHALL keep o_Level equal to entries held, which is never more than DEPTH.
REQ-022 SHALL drive o_Done=1 when the state is STOP and o_Level=0.

Reset
REQ-023 SHALL, while i_RST=0, asynchronously force state IDLE, counter 0, FIFO empty, o_Valid 0, o_Level 0, o_Drops 0, o_DropFlag 0, o_Done 0 and all record outputs 0.
REQ-024 SHALL, on reset asserted mid-operation, discard all pending records with no partial pop; recording resumes only after a fresh i_En.

Structure
REQ-025 SHALL place the flag bit indices (REG=0, MEM=1, OVFL=2, HALT=3), the state encoding and the record-width function in shared package trace_pkg.
REQ-026 SHALL instantiate one sub-module trace_fifo (parametrised width/depth, registered output, full/empty/level) for storage; FSM, stamping and drop logic sit in the top.

Verification
REQ-027 SHALL cover: reset, i_En=1, i_RegWr=1 with addr 0x01 and data 0x00000001 at RUN cycle 0 -> next cycle o_Valid=1, o_Cycle=0, o_Flags=0x1, o_RegAddr=0x01, o_RegData=0x00000001.
REQ-028 SHALL cover: same-cycle i_RegWr, i_DMemWr (addr 0x10010000, data 0xDEADBEEF) and i_Ovfl at cycle 5 -> a single record with o_Flags=0x7 and all fields correct.
REQ-029 SHALL cover: DEPTH=4, i_Ready=0, 6 event cycles -> o_Level=4, o_Drops=2, o_DropFlag=1, and the first 4 records intact in order when drained.
REQ-030 SHALL cover: full FIFO with i_Ready=1 and an event in the same cycle -> o_Level stays 4 and o_Drops is unchanged.
REQ-031 SHALL cover: i_Halt at cycle 9 with i_RegWr asserted at cycles 10-12 -> a last record with o_Flags bit 3 set and o_Cycle=9, no further records, and o_Done=1 after drain.
REQ-032 SHALL cover: i_RST pulsed low with 3 records queued -> o_Valid=0, o_Level=0 and o_Drops=0 immediately, no records until i_En.
